trace_buffer: RTL and testbench



---
 rtl/trace_pkg.sv | 33 +++
 rtl/trace_line_ram.sv | 28 ++
 rtl/trace_buffer.sv | 159 +++++++++++++++
 tb/tb_trace_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the scrolling trace buffer.
package trace_pkg;

    localparam logic [2:0]  TRACE_RGB = 3'b010;
    localparam logic [2:0]  GRID_RGB  = 3'b001;
    localparam int unsigned H_ACTIVE  = 1024;
    localparam int unsigned V_ACTIVE  = 768;
    localparam int unsigned SAMPLE_W  = 9;

    // One screen column: vertical span joining the previous stored sample to this one.
    typedef struct packed {
        logic [SAMPLE_W-1:0] lo;
        logic [SAMPLE_W-1:0] hi;
    } seg_t;

    function automatic seg_t seg_make(input logic [SAMPLE_W-1:0] prev,
                                      input logic [SAMPLE_W-1:0] cur,
                                      input logic                prev_valid);
        seg_t s;
        if (!prev_valid) begin
            s.lo = cur;
            s.hi = cur;
        end else if (prev < cur) begin
            s.lo = prev;
            s.hi = cur;
        end else begin
            s.lo = cur;
            s.hi = prev;
        end
        return s;
    endfunction

endpackage

// File: rtl/trace_line_ram.sv
// Simple dual-port line memory, synchronous read, old data on read-during-write.
module trace_line_ram
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  seg_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output seg_t          rd_data
);

    seg_t mem [DEPTH];
    seg_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_buffer.sv
// Scrolling waveform store feeding the VGA raster; oldest sample at column 0.
// Define TRACE_GRID_EN to overlay a reference grid on the active area.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned AW       = 10,
    parameter int unsigned DECIM    = 4,
    parameter int unsigned V_OFFSET = 128
) (
    input  logic                clk65,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                clear,
    input  logic [10:0]         h_count,
    input  logic [9:0]          v_count,
    input  logic                video_on,
    output logic                pixel_on,
    output logic [2:0]          rgb
);

    localparam int unsigned HW  = 11;
    localparam int unsigned VW  = 10;
    localparam int unsigned RW  = 11;
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DCW-1:0]      decim_cnt_q, decim_cnt_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       fill_cnt_q, fill_cnt_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [AW-1:0]       base_ptr_q, base_ptr_d;
    logic [HW-1:0]       h_d1_q, h_d1_d;
    logic [VW-1:0]       v_d1_q, v_d1_d;
    logic                video_on_d1_q, video_on_d1_d;
    logic                grid_d1_q, grid_d1_d;
    logic                pixel_on_q, pixel_on_d;
    logic [2:0]          rgb_q, rgb_d;

    logic                wr_en_c;
    seg_t                wr_word_c;
    logic [AW-1:0]       rd_addr_c;
    seg_t                rd_word_c;
    logic                grid_c0;
    logic [RW-1:0]       row_c;
    logic                hit_c, col_ok_c, in_range_c, trace_c, grid_c;

    // Decimation, write pointer, fill level and per-frame base latch.
    always_comb begin
        decim_cnt_d  = decim_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        base_ptr_d   = base_ptr_q;
        wr_en_c      = 1'b0;
        wr_word_c    = seg_make(prev_q, sample, prev_valid_q);
        if (clear) begin
            decim_cnt_d  = '0;
            wr_ptr_d     = '0;
            fill_cnt_d   = '0;
            prev_valid_d = 1'b0;
        end else if (sample_valid) begin
            if (decim_cnt_q == DCW'(DECIM - 1)) begin
                decim_cnt_d  = '0;
                wr_en_c      = 1'b1;
                wr_ptr_d     = wr_ptr_q + AW'(1);
                prev_d       = sample;
                prev_valid_d = 1'b1;
                if (fill_cnt_q != CW'(DEPTH)) begin
                    fill_cnt_d = fill_cnt_q + CW'(1);
                end
            end else begin
                decim_cnt_d = decim_cnt_q + DCW'(1);
            end
        end
        // Latch the post-write pointer so a coincident sample lands at the right edge.
        if (h_count == '0 && v_count == '0) begin
            base_ptr_d = wr_ptr_d;
        end
    end

`ifdef TRACE_GRID_EN
    assign grid_c0 = video_on && (h_count[5:0] == '0 || v_count[5:0] == '0 ||
                                  v_count == VW'(V_OFFSET + 256));
`else
    assign grid_c0 = 1'b0;
`endif

    assign rd_addr_c = base_ptr_q + h_count[AW-1:0];

    trace_line_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk65),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_word_c)
    );

    // Stage 0 -> 1: raster coordinates delayed alongside the RAM read.
    always_comb begin
        h_d1_d        = h_count;
        v_d1_d        = v_count;
        video_on_d1_d = video_on;
        grid_d1_d     = grid_c0;
    end

    // Stage 1 -> 2: segment hit test, unfilled-column blanking, colour select.
    always_comb begin
        row_c      = RW'(v_d1_q) - RW'(V_OFFSET);
        hit_c      = !row_c[RW-1] && (RW'(rd_word_c.lo) <= row_c) && (row_c <= RW'(rd_word_c.hi));
        in_range_c = h_d1_q < HW'(DEPTH);
        col_ok_c   = CW'(h_d1_q[AW-1:0]) >= (CW'(DEPTH) - fill_cnt_q);
        trace_c    = video_on_d1_q && in_range_c && col_ok_c && hit_c;
        grid_c     = video_on_d1_q && in_range_c && grid_d1_q;
        pixel_on_d = trace_c || grid_c;
        rgb_d      = trace_c ? TRACE_RGB : (grid_c ? GRID_RGB : 3'b000);
    end

    always_ff @(posedge clk65 or negedge rst_n) begin
        if (!rst_n) begin
            decim_cnt_q   <= '0;
            wr_ptr_q      <= '0;
            fill_cnt_q    <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            base_ptr_q    <= '0;
            h_d1_q        <= '0;
            v_d1_q        <= '0;
            video_on_d1_q <= 1'b0;
            grid_d1_q     <= 1'b0;
            pixel_on_q    <= 1'b0;
            rgb_q         <= '0;
        end else begin
            decim_cnt_q   <= decim_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_cnt_q    <= fill_cnt_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            base_ptr_q    <= base_ptr_d;
            h_d1_q        <= h_d1_d;
            v_d1_q        <= v_d1_d;
            video_on_d1_q <= video_on_d1_d;
            grid_d1_q     <= grid_d1_d;
            pixel_on_q    <= pixel_on_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pixel_on = pixel_on_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: two instances (DECIM=1 and DECIM=4) share all inputs.
module tb_trace_buffer;

    localparam int DEPTH = 1024;
    localparam int VOFF  = 128;

    logic        clk65 = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [8:0]  sample;
    logic        clear;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        video_on;
    logic        pon1, pon4;
    logic [2:0]  rgb1, rgb4;

    always #5 clk65 = ~clk65;

    trace_buffer #(.DEPTH(1024), .AW(10), .DECIM(1), .V_OFFSET(128)) u_dut1 (
        .clk65(clk65), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .clear(clear), .h_count(h_count), .v_count(v_count), .video_on(video_on),
        .pixel_on(pon1), .rgb(rgb1)
    );

    trace_buffer #(.DEPTH(1024), .AW(10), .DECIM(4), .V_OFFSET(128)) u_dut4 (
        .clk65(clk65), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .clear(clear), .h_count(h_count), .v_count(v_count), .video_on(video_on),
        .pixel_on(pon4), .rgb(rgb4)
    );

    typedef struct { int h; int v; bit von; } px_t;
    typedef struct { logic [3:0] e1; logic [3:0] e4; int h; int v; } exp_t;

    px_t  plist[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model per instance: index 0 is DECIM=1, index 1 is DECIM=4.
    bit [8:0] m_lo [2][DEPTH];
    bit [8:0] m_hi [2][DEPTH];
    int       m_wr [2];
    int       m_fill [2];
    int       m_dc [2];
    int       m_base [2];
    bit [8:0] m_prev [2];
    bit       m_pv [2];

    function automatic int decim_of(input int m);
        return (m == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_wr[m] = 0; m_fill[m] = 0; m_dc[m] = 0; m_base[m] = 0; m_pv[m] = 0; m_prev[m] = 0;
        end
    endtask

    task automatic model_step(input bit sv, input bit [8:0] s, input bit clr, input int h, input int v);
        for (int m = 0; m < 2; m++) begin
            if (clr) begin
                m_wr[m] = 0; m_fill[m] = 0; m_dc[m] = 0; m_pv[m] = 0;
            end else if (sv) begin
                if (m_dc[m] == decim_of(m) - 1) begin
                    m_dc[m] = 0;
                    if (!m_pv[m]) begin
                        m_lo[m][m_wr[m]] = s; m_hi[m][m_wr[m]] = s;
                    end else begin
                        m_lo[m][m_wr[m]] = (m_prev[m] < s) ? m_prev[m] : s;
                        m_hi[m][m_wr[m]] = (m_prev[m] < s) ? s : m_prev[m];
                    end
                    m_prev[m] = s;
                    m_pv[m]   = 1;
                    m_wr[m]   = (m_wr[m] + 1) % DEPTH;
                    if (m_fill[m] < DEPTH) m_fill[m]++;
                end else begin
                    m_dc[m]++;
                end
            end
            if (h == 0 && v == 0) m_base[m] = m_wr[m];
        end
    endtask

    function automatic logic [3:0] exp_pix(input int m, input int h, input int v, input bit von);
        bit trace = 0;
        bit grid  = 0;
        int row, a;
        if (!von || h >= DEPTH) return 4'b0000;
        row = v - VOFF;
        a   = (m_base[m] + h) % DEPTH;
        if (h >= DEPTH - m_fill[m] && row >= 0 && int'(m_lo[m][a]) <= row && row <= int'(m_hi[m][a]))
            trace = 1;
`ifdef TRACE_GRID_EN
        grid = (h % 64 == 0) || (v % 64 == 0) || (v == VOFF + 256);
`endif
        if (trace) return 4'b1010;
        if (grid)  return 4'b1001;
        return 4'b0000;
    endfunction

    // One clock: drive inputs, optionally enqueue the expected pixel, advance the model.
    task automatic tick(input int h, input int v, input bit von, input bit sv,
                        input bit [8:0] s, input bit clr, input bit push);
        exp_t e;
        h_count = 11'(h); v_count = 10'(v); video_on = von;
        sample_valid = sv; sample = s; clear = clr;
        if (push) begin
            e.e1 = exp_pix(0, h, v, von);
            e.e4 = exp_pix(1, h, v, von);
            e.h = h; e.v = v;
            sb_q.push_back(e);
        end
        model_step(sv, s, clr, h, v);
        @(posedge clk65);
        #1;
    endtask

    task automatic idle_write(input bit [8:0] s);
        tick(1500, 800, 0, 1, s, 0, 0);
    endtask

    task automatic add_row(input int v, input bit von);
        for (int h = 0; h < DEPTH; h++) plist.push_back('{h, v, von});
    endtask

    task automatic add_px(input int h, input int v, input bit von);
        plist.push_back('{h, v, von});
    endtask

    task automatic test_reset();
        rst_n = 0; sample_valid = 0; sample = 0; clear = 0;
        h_count = 11'd1500; v_count = 10'd800; video_on = 0;
        #1;
        n_checks++; if (pon1 !== 1'b0) begin n_fail++; $display("FAIL reset_pon1 got=%b want=0", pon1); end
        n_checks++; if (rgb1 !== 3'b000) begin n_fail++; $display("FAIL reset_rgb1 got=%b want=000", rgb1); end
        n_checks++; if (pon4 !== 1'b0) begin n_fail++; $display("FAIL reset_pon4 got=%b want=0", pon4); end
        n_checks++; if (rgb4 !== 3'b000) begin n_fail++; $display("FAIL reset_rgb4 got=%b want=000", rgb4); end
        repeat (3) @(posedge clk65);
        #1;
        rst_n = 1;
        model_reset();
        plist.delete();
        add_px(0, 0, 1);
        add_row(0, 1); add_row(127, 1); add_row(128, 1); add_row(228, 1); add_row(384, 1); add_row(767, 1);
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL blank_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL blank_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_flat_line();
        for (int i = 0; i < DEPTH; i++) idle_write(9'd100);
        plist.delete();
        add_px(0, 0, 1);
        add_row(227, 1); add_row(228, 1); add_row(229, 1);
        for (int h = 0; h < 16; h++) add_px(h * 64, 228, 0);
        for (int h = 1024; h < 1032; h++) add_px(h, 228, 1);
        add_px(2047, 228, 1);
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL flat_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL flat_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_segment();
        tick(1500, 800, 0, 0, 0, 1, 0);
        idle_write(9'd10);
        idle_write(9'd50);
        plist.delete();
        add_px(0, 0, 1);
        for (int v = 135; v <= 181; v++) begin
            add_px(1021, v, 1); add_px(1022, v, 1); add_px(1023, v, 1); add_px(0, v, 1);
        end
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL segment_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL segment_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_decim();
        tick(1500, 800, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) idle_write(9'(i * 11));
        plist.delete();
        add_px(0, 0, 1);
        add_row(172, 1);
        for (int v = 170; v <= 218; v++) begin
            add_px(1021, v, 1); add_px(1022, v, 1); add_px(1023, v, 1);
        end
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL decim_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL decim_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_wrap();
        tick(1500, 800, 0, 0, 0, 1, 0);
        for (int i = 0; i < 1030; i++) idle_write(9'(i % 512));
        plist.delete();
        add_px(0, 0, 1);
        add_row(127, 1); add_row(128, 1); add_row(133, 1); add_row(134, 1);
        add_row(135, 1); add_row(383, 1); add_row(639, 1);
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL wrap_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL wrap_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_latch_clear();
        tick(0, 0, 1, 1, 9'd300, 0, 0);
        plist.delete();
        for (int v = 131; v <= 136; v++) begin
            add_px(0, v, 1); add_px(1, v, 1); add_px(1022, v, 1); add_px(1023, v, 1);
        end
        for (int v = 427; v <= 430; v++) begin
            add_px(0, v, 1); add_px(1022, v, 1); add_px(1023, v, 1);
        end
        add_px(1500, 800, 0);
        tick(500, 300, 1, 1, 9'd77, 1, 0);
        idle_write(9'd200);
        add_px(0, 0, 1);
        add_row(205, 1); add_row(328, 1);
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL latch_clear_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL latch_clear_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        plist.delete();
        add_px(0, 0, 1);
        add_px(1023, 328, 1); add_px(1023, 328, 1); add_px(1023, 328, 1);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL pre_reset_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL pre_reset_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
        #2;
        rst_n = 0;
        #1;
        n_checks++; if ({pon1, rgb1} !== 4'b0000) begin n_fail++; $display("FAIL async_reset_d1 got=%b want=0000", {pon1, rgb1}); end
        n_checks++; if ({pon4, rgb4} !== 4'b0000) begin n_fail++; $display("FAIL async_reset_d4 got=%b want=0000", {pon4, rgb4}); end
        model_reset();
        #1;
        rst_n = 1;
        idle_write(9'd60);
        plist.delete();
        add_px(0, 0, 1);
        add_row(188, 1);
        add_px(1500, 800, 0);
        foreach (plist[i]) begin
            tick(plist[i].h, plist[i].v, plist[i].von, 0, 0, 0, 1);
            if (sb_q.size() >= 2) begin
                exp_t e = sb_q.pop_front();
                n_checks++; if ({pon1, rgb1} !== e.e1) begin n_fail++; $display("FAIL resume_d1 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon1, rgb1}, e.e1); end
                n_checks++; if ({pon4, rgb4} !== e.e4) begin n_fail++; $display("FAIL resume_d4 h=%0d v=%0d got=%b want=%b", e.h, e.v, {pon4, rgb4}, e.e4); end
            end
        end
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_flat_line();
        test_segment();
        test_decim();
        test_wrap();
        test_latch_clear();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
